// File: rtl/deu_ib_seq.sv
// deu_ib_seq: sequencing controller for the 4-entry decode instruction buffer.
// Tracks entry validity, places fetches, shifts on consume, and gates fetches after a flush.
module deu_ib_seq #(
    parameter int unsigned FLUSH_KILL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ifu_i0_valid,
    input  logic       ifu_i1_valid,
    output logic       ifu_ready,
    input  logic       dec_i0_decode_d,
    input  logic       dec_i1_decode_d,
    input  logic       flush,
    output logic [3:0] ibval,
    output logic [3:0] write_i0_ib,
    output logic [3:0] write_i1_ib,
    output logic       shift_ib1_ib0,
    output logic       shift_ib2_ib0,
    output logic       shift_ib2_ib1,
    output logic       shift_ib3_ib1,
    output logic       shift_ib3_ib2,
    output logic [3:0] ib_we
);
    typedef enum logic {RUN, KILL} mode_t;
    localparam logic [2:0] KILL_LOAD = 3'(FLUSH_KILL_CYCLES);
    mode_t      mode_q, mode_d;
    logic [2:0] kill_cnt_q, kill_cnt_d;
    logic [3:0] ibval_q, ibval_d;
    logic [2:0] n, c, m, fill;
    logic       c0, c1, w0, w1, kill_go;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibval_q    <= 4'b0000;
            mode_q     <= RUN;
            kill_cnt_q <= 3'd0;
        end else begin
            ibval_q    <= ibval_d;
            mode_q     <= mode_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end
    assign ibval = ibval_q;
    always_comb begin
        n = 3'(ibval_q[0]) + 3'(ibval_q[1]) + 3'(ibval_q[2]) + 3'(ibval_q[3]);
        // flush suppresses consume so no shift or enable fires while emptying
        c0 = dec_i0_decode_d & ibval_q[0] & ~flush;
        c1 = c0 & dec_i1_decode_d & ibval_q[1];
        c = 3'(c0) + 3'(c1);
        m = n - c;
        ifu_ready = (mode_q == RUN) & ~ibval_q[2];
        w0 = ifu_i0_valid & ifu_ready & ~flush;
        w1 = w0 & ifu_i1_valid;
        shift_ib1_ib0 = c0 & ~c1 & ibval_q[1];
        shift_ib2_ib1 = c0 & ~c1 & ibval_q[2];
        shift_ib3_ib2 = c0 & ~c1 & ibval_q[3];
        shift_ib2_ib0 = c1 & ibval_q[2];
        shift_ib3_ib1 = c1 & ibval_q[3];
        write_i0_ib = w0 ? 4'b0001 << m : 4'b0000;
        write_i1_ib = w1 ? 4'b0010 << m : 4'b0000;
        ib_we = write_i0_ib | write_i1_ib |
                {1'b0, shift_ib3_ib2, shift_ib2_ib1 | shift_ib3_ib1, shift_ib1_ib0 | shift_ib2_ib0};
        fill = m + 3'(w0) + 3'(w1);
        ibval_d = flush ? 4'b0000 : 4'((5'd1 << fill) - 5'd1);
        kill_go = flush && (FLUSH_KILL_CYCLES != 0);
        mode_d = kill_go ? KILL : (mode_q == KILL && kill_cnt_q > 3'd1) ? KILL : RUN;
        kill_cnt_d = kill_go ? KILL_LOAD : (mode_d == KILL) ? kill_cnt_q - 3'd1 : 3'd0;
    end
endmodule

// File: tb/tb_deu_ib_seq.sv
// tb_deu_ib_seq: directed bench for deu_ib_seq with a two-cycle kill window.
// Combinational controls are checked in-cycle; next-cycle ibval goes through a scoreboard queue.
module tb_deu_ib_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i0v = 1'b0, i1v = 1'b0, d0 = 1'b0, d1 = 1'b0, fl = 1'b0;
    logic       rdy, s10, s20, s21, s31, s32;
    logic [3:0] ibval, w0, w1, we;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    deu_ib_seq #(.FLUSH_KILL_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .ifu_i0_valid(i0v), .ifu_i1_valid(i1v), .ifu_ready(rdy),
        .dec_i0_decode_d(d0), .dec_i1_decode_d(d1), .flush(fl),
        .ibval(ibval), .write_i0_ib(w0), .write_i1_ib(w1),
        .shift_ib1_ib0(s10), .shift_ib2_ib0(s20), .shift_ib2_ib1(s21),
        .shift_ib3_ib1(s31), .shift_ib3_ib2(s32), .ib_we(we)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // shift vector order: {s10, s20, s21, s31, s32}
    task automatic step(input string tag, input logic a0, input logic a1, input logic e0,
                        input logic e1, input logic f, input logic e_rdy,
                        input logic [3:0] e_w0, input logic [3:0] e_w1, input logic [4:0] e_sh,
                        input logic [3:0] e_we, input logic [3:0] e_nib);
        logic [3:0] nib;
        @(negedge clk);
        i0v = a0; i1v = a1; d0 = e0; d1 = e1; fl = f;
        #1;
        chk({tag, ".rdy"}, {7'b0, rdy}, {7'b0, e_rdy});
        chk({tag, ".w0"}, {4'b0, w0}, {4'b0, e_w0});
        chk({tag, ".w1"}, {4'b0, w1}, {4'b0, e_w1});
        chk({tag, ".sh"}, {3'b0, s10, s20, s21, s31, s32}, {3'b0, e_sh});
        chk({tag, ".we"}, {4'b0, we}, {4'b0, e_we});
        sb.push_back(e_nib);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s.sb: observed empty queue expected one entry", tag);
        end else begin
            nib = sb.pop_front();
            chk({tag, ".ibval"}, {4'b0, ibval}, {4'b0, nib});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.ibval", {4'b0, ibval}, 8'h00);
        chk("rst.rdy", {7'b0, rdy}, 8'h01);
        chk("rst.we", {4'b0, we}, 8'h00);
        rst = 1'b0;
        //   tag        i0 i1 d0 d1 fl rdy  w0       w1       sh        we       next ibval
        step("idle",    0, 0, 1, 0, 0, 1, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("fill2",   1, 1, 0, 0, 0, 1, 4'b0001, 4'b0010, 5'b00000, 4'b0011, 4'b0011);
        step("fill4",   1, 1, 0, 0, 0, 1, 4'b0100, 4'b1000, 5'b00000, 4'b1100, 4'b1111);
        step("full_d0", 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 5'b10101, 4'b0111, 4'b0111);
        step("d1_only", 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0111);
        step("3_d01",   0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 5'b01000, 4'b0001, 4'b0001);
        step("1_d0_f2", 1, 1, 1, 0, 0, 1, 4'b0001, 4'b0010, 5'b00000, 4'b0011, 4'b0011);
        step("2_d01_f2",1, 1, 1, 1, 0, 1, 4'b0001, 4'b0010, 5'b00000, 4'b0011, 4'b0011);
        step("i1_only", 0, 1, 0, 0, 0, 1, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0011);
        step("2_d0_f1", 1, 0, 1, 0, 0, 1, 4'b0010, 4'b0000, 5'b10000, 4'b0011, 4'b0011);
        step("refill4", 1, 1, 0, 0, 0, 1, 4'b0100, 4'b1000, 5'b00000, 4'b1100, 4'b1111);
        step("full_d01",0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 5'b01010, 4'b0011, 4'b0011);
        step("fill3",   1, 0, 0, 0, 0, 1, 4'b0100, 4'b0000, 5'b00000, 4'b0100, 4'b0111);
        step("flush3",  1, 1, 1, 0, 1, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("kill1",   1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("kill2",   1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("kill_end",1, 1, 0, 0, 0, 1, 4'b0001, 4'b0010, 5'b00000, 4'b0011, 4'b0011);
        step("flush2",  1, 0, 1, 1, 1, 1, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("reflush", 1, 1, 0, 0, 1, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("rk1",     1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("rk2",     1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 5'b00000, 4'b0000, 4'b0000);
        step("rk_end",  1, 1, 0, 0, 0, 1, 4'b0001, 4'b0010, 5'b00000, 4'b0011, 4'b0011);
        @(negedge clk);
        i0v = 1'b0; i1v = 1'b0; d0 = 1'b0; d1 = 1'b0; fl = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst.ibval", {4'b0, ibval}, 8'h00);
        chk("arst.rdy", {7'b0, rdy}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst",1, 1, 0, 0, 0, 1, 4'b0001, 4'b0010, 5'b00000, 4'b0011, 4'b0011);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
